// File: rtl/cache_def.sv
// ============================================================================
// cache_def : types shared between the cache controller and memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_def;

  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } mem_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_line_array.sv
// ============================================================================
// mem_line_array : DEPTH x 128-bit line store, async read, sync write
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_line_array
  import cache_def::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] lines [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lines[i] <= '0;
      end
    end else if (we) begin
      lines[widx] <= wdata;
    end
  end

  assign rdata = lines[ridx];

endmodule

`default_nettype wire

// File: rtl/mem_line_responder.sv
// ============================================================================
// mem_line_responder : fixed-latency line read/write responder for the cache
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_line_responder
  import cache_def::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_resp_state_t   state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  lat_idx;
  logic [LINE_W-1:0] lat_data;
  logic              lat_rw;

  logic              go_resp;
  logic [IDX_W-1:0]  cur_idx;
  logic [LINE_W-1:0] cur_data;
  logic              cur_rw;
  logic [LINE_W-1:0] rdata;

  // With LATENCY == 1 the accepting edge is also the edge entering RESP, so
  // the transaction is taken straight from the request bus instead of latches.
  assign go_resp  = ((state == IDLE) && mem_req.valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == 4'd1));
  assign cur_idx  = (state == IDLE) ? mem_req.addr[OFFSET_W +: IDX_W] : lat_idx;
  assign cur_data = (state == IDLE) ? mem_req.data : lat_data;
  assign cur_rw   = (state == IDLE) ? mem_req.rw   : lat_rw;

  mem_line_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (go_resp && cur_rw),
    .widx  (cur_idx),
    .wdata (cur_data),
    .ridx  (cur_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_rw   <= 1'b0;
      mem_data <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      mem_data.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req.valid) begin
            lat_idx  <= mem_req.addr[OFFSET_W +: IDX_W];
            lat_data <= mem_req.data;
            lat_rw   <= mem_req.rw;
            cnt      <= CNT_INIT;
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (go_resp) begin
        mem_data.ready <= 1'b1;
        mem_data.data  <= cur_rw ? cur_data : rdata;
        if (cur_rw) wr_count <= wr_count + 32'd1;
        else        rd_count <= rd_count + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the direct-mapped cache controller's memory request/response interface.
- Accepts one 128-bit line read or write per request, applies a programmable fixed latency, and returns a one-cycle ready pulse with line data.
- Serves as the backing store for cache simulation and bring-up, and as the reference responder for cache-controller regression.

Parameters:
- DEPTH, 256, number of 128-bit lines held; power of two, at least 2.
- LATENCY, 4, clock edges from request acceptance to the ready pulse; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_req  input  mem_req_type (162)  request bundle from the cache:
  - addr[31:0]
  - data[127:0], write line
  - rw, 1 = write
  - valid
- mem_data  output  mem_data_type (129)  response bundle:
  - data[127:0], read line or echoed write line
  - ready, single-cycle completion
- rd_count  output  32  count of completed reads.
- wr_count  output  32  count of completed writes.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - mem_data.ready = 0 and mem_data.data = 0.
  - rd_count = wr_count = 0, latch registers = 0, all DEPTH lines = 0.
  - Reset asserted mid-operation abandons the transaction: no ready pulse and no array write.
- Indexing:
  - idx = addr[4 +: $clog2(DEPTH)]; addr[3:0] is ignored.
  - Upper address bits are ignored, so addresses alias modulo DEPTH*16 bytes.
- State machine, all outputs registered:
  - IDLE: if mem_req.valid is 1 at a rising edge, latch addr, data and rw, and load cnt = LATENCY-1.
    - If LATENCY == 1, go to RESP; otherwise go to WAIT.
  - WAIT: decrement cnt each edge; when cnt reaches 1, go to RESP on that edge.
  - RESP: mem_data.ready = 1 for exactly this one cycle.
    - Read: mem_data.data = array[latched idx]; rd_count += 1.
    - Write: array[latched idx] <= latched data at the edge entering RESP; mem_data.data = latched data; wr_count += 1.
    - Next state is GAP.
  - GAP: ready = 0; mem_req.valid is ignored for this one cycle; next state is IDLE.
    - Purpose: a cache that holds valid one cycle past ready cannot trigger a duplicate request.
- Latency: ready is high in the cycle immediately after the LATENCY-th rising edge, counting the accepting edge as edge 1.
- Requester changes while a transaction is in flight: mem_req changes during WAIT, RESP or GAP are ignored; only latched values are used.
- Response data hold: mem_data.data holds its last value outside RESP. Consumers must sample it only while ready = 1.
- Counters: rd_count and wr_count wrap at 2^32 with no saturation.
- Throughput: at most one request every LATENCY+2 cycles; there is no queueing.
- Write vs. read ordering: a read to an index written by the previous transaction returns the new data.

Decomposition:
- Shared package cache_def holds:
  - mem_req_type and mem_data_type (already shared with the cache controller).
  - Constant LINE_W = 128.
  - Constant OFFSET_W = 4.
  - State enum mem_resp_state_t {IDLE, WAIT, RESP, GAP}.
- One sub-module, mem_line_array: DEPTH x 128 storage.
  - Ports: clk, rst, we, widx, wdata, ridx, rdata.
  - Asynchronous read; synchronous write; asynchronous active-low clear.
- The FSM, latency counter and statistics counters live in mem_line_responder.

Test Plan:
- Reset: hold rst low, then release → mem_data.ready = 0, mem_data.data = 0, rd_count = wr_count = 0; a read of 0x12345678 returns 128'h0.
- Write then read-back: write 0x12345678 with data 128'h00112233445566778899aabbccddeeff.
  - Ready pulses exactly once, 4 edges after acceptance.
  - A following read of 0x12345670 returns the same line with rd_count = 1, wr_count = 1.
- Aliasing: write 0xFFFF0670 with 128'hA5…A5 (all bytes A5) → a read of 0x00000670 (idx 0x67) returns 128'hA5…A5.
- Held valid: keep valid = 1 continuously with a read to 0x100 for 20 cycles → one ready per 6 cycles (LATENCY = 4) and no extra pulse in GAP; rd_count = 3 at cycle 18.
- Reset mid-operation: accept a write of 128'h1 to 0x200, pull rst low during WAIT, then release.
  - No ready pulse and wr_count = 0.
  - A read of 0x200 returns 0.
- LATENCY = 1 build: read 0x40 → ready is high in the cycle right after the accepting edge; data = 0.
